// File: rtl/sdram_arb_pkg.sv
// Shared widths and FSM encoding for the SDRAM read port 3 arbiter.
package sdram_arb_pkg;

   localparam int SDRAM_ADDR_W = 21;
   localparam int SDRAM_LEN_W  = 32;
   localparam int SEQ_CNT_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_START = 3'd2,
      ST_XFER  = 3'd3,
      ST_DONE  = 3'd4
   } arb_state_e;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: one delay register and an AND gate.
module edge_rise_det (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_rise
);

   logic sig_q;
   logic sig_d;

   assign sig_d  = i_sig;
   assign o_rise = i_sig & ~sig_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sig_q <= 1'b0;
      else          sig_q <= sig_d;
   end

endmodule

// File: rtl/sdram_rd_tunnel_arb.sv
// Round-robin arbiter and sequencer for SDRAM read port 3,
// serving the video readout and flash copy read tunnels.
module sdram_rd_tunnel_arb
   import sdram_arb_pkg::*;
#(
   parameter int SETUP_CYC = 3,
   parameter int START_CYC = 5,
   parameter int TMO_W     = 24
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_rd_0_start,
   input  logic [SDRAM_ADDR_W-1:0] i_rd_0_addrs,
   input  logic [SDRAM_LEN_W-1:0]  i_rd_0_lengths,
   output logic                    o_rd_0_grant,
   output logic                    o_rd_0_done,
   input  logic                    i_rd_1_start,
   input  logic [SDRAM_ADDR_W-1:0] i_rd_1_addrs,
   input  logic [SDRAM_LEN_W-1:0]  i_rd_1_lengths,
   output logic                    o_rd_1_grant,
   output logic                    o_rd_1_done,
   output logic                    o_tunnel_id,
   output logic                    o_mem_rd3_start,
   output logic [SDRAM_ADDR_W-1:0] o_mem_rd3_addrs,
   output logic [SDRAM_LEN_W-1:0]  o_mem_rd3_lens,
   input  logic                    i_mem_rd3_data_vld,
   output logic                    o_err
);

   localparam logic [SEQ_CNT_W-1:0] SETUP_LAST = SEQ_CNT_W'(SETUP_CYC - 1);
   localparam logic [SEQ_CNT_W-1:0] START_LAST = SEQ_CNT_W'(START_CYC - 1);

   arb_state_e              state_q, state_d;
   logic [1:0]              rise;
   logic [1:0]              pend_q, pend_d;
   logic [1:0]              grant_q, grant_d;
   logic                    ptr_q, ptr_d;
   logic                    id_q, id_d;
   logic                    err_q, err_d;
   logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SDRAM_LEN_W-1:0]  len_q, len_d;
   logic [SDRAM_LEN_W-1:0]  beat_q, beat_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [SEQ_CNT_W-1:0]    seq_q, seq_d;

   logic                    sel;
   logic [SDRAM_ADDR_W-1:0] sel_addr;
   logic [SDRAM_LEN_W-1:0]  sel_len;
   logic [SDRAM_LEN_W-1:0]  beat_inc;
   logic [SDRAM_LEN_W-1:0]  beat_nxt;
   logic [TMO_W-1:0]        tmo_inc;
   logic                    tmo_exp;

   edge_rise_det u_rise_0 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_rd_0_start),
      .o_rise  (rise[0])
   );

   edge_rise_det u_rise_1 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_rd_1_start),
      .o_rise  (rise[1])
   );

   always_comb begin
      // lone requester wins; on a tie the pointer decides
      sel      = pend_q[1] & (~pend_q[0] | ptr_q);
      sel_addr = sel ? i_rd_1_addrs : i_rd_0_addrs;
      sel_len  = sel ? i_rd_1_lengths : i_rd_0_lengths;
      beat_inc = beat_q + 1'b1;
      beat_nxt = i_mem_rd3_data_vld ? beat_inc : beat_q;
      // counts cycles since the last beat, so all-ones marks the deadline
      tmo_inc  = (i_mem_rd3_data_vld ? '0 : tmo_q) + 1'b1;
      tmo_exp  = &tmo_inc;

      state_d = state_q;
      pend_d  = pend_q | rise;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      err_d   = 1'b0;
      addr_d  = addr_q;
      len_d   = len_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      seq_d   = seq_q;

      unique case (state_q)
         ST_IDLE: begin
            if (|pend_q) begin
               pend_d[sel] = rise[sel];
               id_d        = sel;
               grant_d     = {sel, ~sel};
               addr_d      = sel_addr;
               len_d       = sel_len;
               beat_d      = '0;
               tmo_d       = '0;
               seq_d       = '0;
               state_d     = (sel_len == '0) ? ST_DONE : ST_SETUP;
            end
         end
         ST_SETUP: begin
            seq_d = seq_q + 1'b1;
            if (seq_q == SETUP_LAST) begin
               seq_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            seq_d  = seq_q + 1'b1;
            tmo_d  = tmo_inc;
            beat_d = beat_nxt;
            if (tmo_exp) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (seq_q == START_LAST) begin
               seq_d   = '0;
               state_d = (beat_nxt >= len_q) ? ST_DONE : ST_XFER;
            end
         end
         ST_XFER: begin
            tmo_d  = tmo_inc;
            beat_d = beat_nxt;
            if (i_mem_rd3_data_vld && (beat_inc == len_q)) begin
               state_d = ST_DONE;
            end else if (tmo_exp) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = ~id_q;
            beat_d  = '0;
            tmo_d   = '0;
            seq_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         grant_q <= '0;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         tmo_q   <= '0;
         seq_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         seq_q   <= seq_d;
      end
   end

   assign o_rd_0_grant    = grant_q[0];
   assign o_rd_1_grant    = grant_q[1];
   assign o_rd_0_done     = (state_q == ST_DONE) & grant_q[0];
   assign o_rd_1_done     = (state_q == ST_DONE) & grant_q[1];
   assign o_tunnel_id     = id_q;
   assign o_mem_rd3_start = (state_q == ST_START);
   assign o_mem_rd3_addrs = addr_q;
   assign o_mem_rd3_lens  = len_q;
   assign o_err           = err_q;

endmodule
